// File: rtl/instr_fetch_buffer.sv
// Fetch stage in front of the L0 I-cache: line requests, line FIFO, 32-bit instruction stream, redirects.
// Optional FETCH_BUF_PERF_CNT_EN adds saturating stall/flush counters.
module instr_fetch_buffer #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en_i,
  input  logic                  branch_i,
  input  logic [31:0]           branch_addr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_rdata_o,
  output logic [31:0]           instr_addr_o,
  output logic                  cache_en_o,
  output logic [31:0]           cache_addr_o,
  input  logic                  cache_gnt_i,
  input  logic                  cache_rvalid_i,
  input  logic [LINE_WIDTH-1:0] cache_rdata_i
`ifdef FETCH_BUF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_flush_cnt_o
`endif
);

  localparam int unsigned WORDS = LINE_WIDTH / 32;
  localparam int unsigned OFFS  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned WIDX  = OFFS - 2;
  localparam int unsigned PTRW  = $clog2(FIFO_DEPTH);
  localparam logic [31:0]     LINE_BYTES = 32'(LINE_WIDTH / 8);
  localparam logic [WIDX-1:0] LAST_WORD  = WIDX'(WORDS - 1);
  localparam logic [PTRW:0]   DEPTH_C    = (PTRW + 1)'(FIFO_DEPTH);

  // state       | meaning
  // IDLE        | no request pending, may request
  // WAIT_GNT    | cache_en_o held, waiting for grant
  // WAIT_RVALID | one request granted, line not yet returned
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} req_state_e;

  req_state_e state_q, state_d;
  logic       outstanding;

  logic                  discard_q, discard_d;
  logic                  first_q, first_d;
  logic [31:0]           next_line_q, next_line_d;
  logic [WIDX-1:0]       start_word_q, start_word_d;
  logic [WIDX-1:0]       rd_word_q, rd_word_d;
  logic [PTRW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTRW:0]         count_q, count_d;
  logic [LINE_WIDTH-1:0] line_q  [FIFO_DEPTH];
  logic [31:0]           laddr_q [FIFO_DEPTH];

  logic                  req_fire, push, accept, pop;
  logic [LINE_WIDTH-1:0] head_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, WAIT_GNT: begin
        if (req_fire)        state_d = WAIT_RVALID;
        else if (cache_en_o) state_d = WAIT_GNT;
        else                 state_d = IDLE;
      end
      WAIT_RVALID: if (cache_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outstanding  = (state_q == WAIT_RVALID);
    cache_en_o   = fetch_en_i & ~branch_i & ~outstanding & (count_q < DEPTH_C);
    cache_addr_o = next_line_q;
  end

  assign req_fire      = cache_en_o & cache_gnt_i;
  assign push          = cache_rvalid_i & ~discard_q & ~branch_i;
  assign instr_valid_o = (count_q != '0) & ~branch_i;
  assign accept        = instr_valid_o & instr_ready_i;
  assign pop           = accept & (rd_word_q == LAST_WORD);

  assign head_line     = line_q[rd_ptr_q];
  assign instr_rdata_o = head_line[{rd_word_q, 5'b0} +: 32];
  assign instr_addr_o  = laddr_q[rd_ptr_q] + {{(30 - WIDX){1'b0}}, rd_word_q, 2'b00};

  always_comb begin
    discard_d    = discard_q;
    first_d      = first_q;
    next_line_d  = next_line_q;
    start_word_d = start_word_q;
    rd_word_d    = rd_word_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    if (branch_i) begin
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      rd_word_d    = '0;
      first_d      = 1'b1;
      start_word_d = branch_addr_i[OFFS-1:2];
      next_line_d  = {branch_addr_i[31:OFFS], {OFFS{1'b0}}};
      // A line already in flight belongs to the old path and must be dropped on return.
      if (cache_rvalid_i)   discard_d = 1'b0;
      else if (outstanding) discard_d = 1'b1;
    end else begin
      if (req_fire) next_line_d = next_line_q + LINE_BYTES;
      if (cache_rvalid_i && discard_q) discard_d = 1'b0;
      if (accept) begin
        if (pop) begin
          rd_word_d = '0;
          rd_ptr_d  = rd_ptr_q + 1'b1;
        end else begin
          rd_word_d = rd_word_q + 1'b1;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        // The first line of a new path lands in an empty FIFO, so no pop can collide here.
        if (first_q) begin
          rd_word_d = start_word_q;
          first_d   = 1'b0;
        end
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard_q    <= 1'b0;
      first_q      <= 1'b1;
      next_line_q  <= {BOOT_ADDR[31:OFFS], {OFFS{1'b0}}};
      start_word_q <= BOOT_ADDR[OFFS-1:2];
      rd_word_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        line_q[i]  <= '0;
        laddr_q[i] <= '0;
      end
    end else begin
      discard_q    <= discard_d;
      first_q      <= first_d;
      next_line_q  <= next_line_d;
      start_word_q <= start_word_d;
      rd_word_q    <= rd_word_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      // next_line has already advanced past the granted line, so the returning line is one behind.
      if (push) begin
        line_q[wr_ptr_q]  <= cache_rdata_i;
        laddr_q[wr_ptr_q] <= next_line_q - LINE_BYTES;
      end
    end
  end

`ifdef FETCH_BUF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (instr_ready_i && !instr_valid_o && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (branch_i && (count_q != '0 || outstanding) && flush_cnt_q != 32'hFFFF_FFFF)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule
